alu_pipe: RTL and testbench

//  Registered, parametrised datapath ALU for the next-generation SimpleRISC core. Extends the 4-op combinational ALU to 8 ops
//  (adds OR, XOR, SHL, iterative MUL) with valid/ready handshakes on input and output, registered result and N/V/Z flags.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_pipe_mul_iter.sv | 61 ++++++
 rtl/alu_pipe.sv | 170 +++++++++++++++++
 tb/tb_alu_pipe.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and helpers for the registered ALU datapath.
//   alu_op_t    : 3-bit operation encoding presented on ALUop
//   alu_state_t : control FSM states (idle, multiply running, multiply result waiting for slot)
//   add_ovf/sub_ovf : signed-overflow rules on operand/result sign bits
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_NOTB = 3'b011,
        OP_OR   = 3'b100,
        OP_XOR  = 3'b101,
        OP_SHL  = 3'b110,
        OP_MUL  = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_HOLD = 2'b10
    } alu_state_t;

    // Operands of equal sign whose sum changes sign.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    // Operands of differing sign whose difference takes B's sign.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_pipe_mul_iter.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
//   clk, reset : clock, async active-high reset
//   start      : latch a/b and begin (first partial product is taken on the start edge)
//   a, b       : W-bit unsigned operands
//   done       : product complete; held until the next start
//   prod       : 2W-bit product, stable while done
// The first step is folded into the start edge so the product is ready
// W-1 edges later; the caller then loads it on the following edge.
module mul_iter #(
    parameter int unsigned W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             done,
    output logic [2*W-1:0]   prod
);

    localparam int unsigned CW = $clog2(W);
    localparam int unsigned PW = 2 * W;
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 2);

    logic [PW-1:0] acc;
    logic [PW-1:0] mcand;
    logic [W-1:0]  mplier;
    logic [CW-1:0] count;
    logic          running;

    // Partial-product accumulation and step counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else if (start) begin
            acc     <= b[0] ? {{W{1'b0}}, a} : '0;
            mcand   <= {{(W-1){1'b0}}, a, 1'b0};
            mplier  <= {1'b0, b[W-1:1]};
            count   <= '0;
            running <= 1'b1;
            done    <= 1'b0;
        end else if (running) begin
            acc    <= acc + (mplier[0] ? mcand : '0);
            mcand  <= {mcand[PW-2:0], 1'b0};
            mplier <= {1'b0, mplier[W-1:1]};
            count  <= count + CW'(1);
            if (count == LAST_STEP) begin
                running <= 1'b0;
                done    <= 1'b1;
            end
        end
    end

    assign prod = acc;

endmodule

// File: rtl/alu_pipe.sv
// Registered 8-op ALU with valid/ready on both sides and N/V/Z flags.
//   clk, reset          : clock, async active-high reset
//   in_valid/in_ready   : operation handshake (Ain, Bin, ALUop)
//   out_valid/out_ready : result handshake (out, N_sig, V_sig, Z_sig)
//   busy                : multiply in progress
// Single-cycle ops load the output slot on the accept edge. MUL runs in
// mul_iter for W cycles and then loads the slot, or parks in HOLD if the
// slot is still occupied.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned W      = 16,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] Ain,
    input  logic [W-1:0] Bin,
    input  logic [2:0]   ALUop,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic         N_sig,
    output logic         V_sig,
    output logic         Z_sig,
    output logic         busy
);

    localparam int unsigned SW = $clog2(W);
    localparam int unsigned PW = 2 * W;

    alu_state_t    state_q;
    alu_state_t    state_nxt_c;
    alu_op_t       op_c;
    logic          slot_free_c;
    logic          accept_c;
    logic          is_mul_c;
    logic          mul_start_c;
    logic          load_alu_c;
    logic          load_mul_c;
    logic [W-1:0]  alu_res_c;
    logic          alu_v_c;
    logic [W-1:0]  res_sel_c;
    logic          v_sel_c;
    logic          mul_done;
    logic [PW-1:0] mul_prod;

    assign op_c        = alu_op_t'(ALUop);
    assign slot_free_c = !out_valid || out_ready;
    assign accept_c    = in_valid && in_ready;
    assign is_mul_c    = MUL_EN && (op_c == OP_MUL);
    assign mul_start_c = accept_c && is_mul_c;

    // Multiplier exists only when enabled; otherwise the FSM never leaves IDLE.
    if (MUL_EN) begin : g_mul
        mul_iter #(.W(W)) u_mul (
            .clk   (clk),
            .reset (reset),
            .start (mul_start_c),
            .a     (Ain),
            .b     (Bin),
            .done  (mul_done),
            .prod  (mul_prod)
        );
    end else begin : g_no_mul
        assign mul_done = 1'b0;
        assign mul_prod = '0;
    end

    // Single-cycle result and overflow; op 111 only lands here when MUL is disabled.
    always_comb begin
        alu_res_c = '0;
        alu_v_c   = 1'b0;
        case (op_c)
            OP_ADD: begin
                alu_res_c = Ain + Bin;
                alu_v_c   = add_ovf(Ain[W-1], Bin[W-1], alu_res_c[W-1]);
            end
            OP_SUB: begin
                alu_res_c = Ain - Bin;
                alu_v_c   = sub_ovf(Ain[W-1], Bin[W-1], alu_res_c[W-1]);
            end
            OP_AND:  alu_res_c = Ain & Bin;
            OP_NOTB: alu_res_c = ~Bin;
            OP_OR:   alu_res_c = Ain | Bin;
            OP_XOR:  alu_res_c = Ain ^ Bin;
            OP_SHL:  alu_res_c = Ain << Bin[SW-1:0];
            OP_MUL: begin
                alu_res_c = '0;
                alu_v_c   = 1'b1;
            end
            default: begin
                alu_res_c = '0;
                alu_v_c   = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt_c;
        end
    end

    // FSM next state.
    always_comb begin
        state_nxt_c = state_q;
        case (state_q)
            S_IDLE: if (mul_start_c) state_nxt_c = S_MUL;
            S_MUL: begin
                if (mul_done) state_nxt_c = slot_free_c ? S_IDLE : S_HOLD;
            end
            S_HOLD: if (out_ready) state_nxt_c = S_IDLE;
            default: state_nxt_c = S_IDLE;
        endcase
    end

    // FSM outputs: handshake and slot-load controls.
    always_comb begin
        in_ready   = 1'b0;
        busy       = 1'b0;
        load_alu_c = 1'b0;
        load_mul_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready   = slot_free_c;
                load_alu_c = in_valid && slot_free_c && !is_mul_c;
            end
            S_MUL: begin
                busy       = 1'b1;
                load_mul_c = mul_done && slot_free_c;
            end
            S_HOLD: begin
                busy       = 1'b1;
                load_mul_c = out_ready;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign res_sel_c = load_mul_c ? mul_prod[W-1:0] : alu_res_c;
    assign v_sel_c   = load_mul_c ? (|mul_prod[PW-1:W]) : alu_v_c;

    // Output slot: a new result wins over a pop on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out       <= '0;
            N_sig     <= 1'b0;
            V_sig     <= 1'b0;
            Z_sig     <= 1'b0;
            out_valid <= 1'b0;
        end else if (load_alu_c || load_mul_c) begin
            out       <= res_sel_c;
            N_sig     <= res_sel_c[W-1];
            V_sig     <= v_sel_c;
            Z_sig     <= (res_sel_c == '0);
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int unsigned W = 16;

    typedef struct packed {
        logic [W-1:0] res;
        logic         n;
        logic         v;
        logic         z;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] Ain;
    logic [W-1:0] Bin;
    logic [2:0]   ALUop;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         N_sig;
    logic         V_sig;
    logic         Z_sig;
    logic         busy;

    exp_t         sb_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    logic         bp_en   = 1'b0;
    logic         prev_stall = 1'b0;
    logic [W+2:0] prev_snap;

    alu_pipe #(.W(W), .MUL_EN(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Ain       (Ain),
        .Bin       (Bin),
        .ALUop     (ALUop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .N_sig     (N_sig),
        .V_sig     (V_sig),
        .Z_sig     (Z_sig),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model using signed integer range checks for overflow.
    function automatic exp_t model(input alu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         e;
        int           sa;
        int           sb;
        int           sr;
        logic [31:0]  p;
        e  = '0;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            OP_ADD: begin sr = sa + sb; e.res = W'(sr); e.v = (sr > 32767) || (sr < -32768); end
            OP_SUB: begin sr = sa - sb; e.res = W'(sr); e.v = (sr > 32767) || (sr < -32768); end
            OP_AND:  e.res = a & b;
            OP_NOTB: e.res = ~b;
            OP_OR:   e.res = a | b;
            OP_XOR:  e.res = a ^ b;
            OP_SHL: begin
                p = {16'h0, a};
                for (int i = 0; i < int'(b[3:0]); i++) p = p * 2;
                e.res = p[15:0];
            end
            default: begin
                p     = {16'h0, a} * {16'h0, b};
                e.res = p[15:0];
                e.v   = |p[31:16];
            end
        endcase
        e.n = e.res[W-1];
        e.z = (e.res == '0);
        return e;
    endfunction

    // Scoreboard pop on each output handshake, plus hold-stability under back-pressure.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("hold_stable", {out, N_sig, V_sig, Z_sig}, prev_snap);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("result", out, e.res);
                    check("flags", {N_sig, V_sig, Z_sig}, {e.n, e.v, e.z});
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_snap  = {out, N_sig, V_sig, Z_sig};
        end
    end

    // Random consumer back-pressure.
    always @(posedge clk) begin
        #1;
        if (bp_en) out_ready = 1'($urandom_range(0, 1));
    end

    // Present one op, wait (bounded) for acceptance, push its expected result.
    task automatic issue(input alu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
        int waited;
        waited   = 0;
        ALUop    = op;
        Ain      = a;
        Bin      = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb_q.push_back(model(op, a, b));
        #1;
        in_valid = 1'b0;
        Ain      = W'($urandom);
        Bin      = W'($urandom);
    endtask

    // Cycles from the accept edge until out_valid rises.
    task automatic mul_latency(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        issue(OP_MUL, a, b);
        check("mul_busy", busy, 1);
        check("mul_in_ready", in_ready, 0);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mul_latency", n, 16);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        Ain       = '0;
        Bin       = '0;
        ALUop     = 3'b000;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_outputs", {out, N_sig, V_sig, Z_sig, busy}, 0);
        reset = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Directed single-cycle ops.
        issue(OP_ADD, 16'h7FFF, 16'h0001);
        check("add_valid", out_valid, 1);
        check("add_out", out, 16'h8000);
        check("add_nvz", {N_sig, V_sig, Z_sig}, 3'b110);
        issue(OP_SUB, 16'h8000, 16'h0001);
        check("sub_out", out, 16'h7FFF);
        check("sub_nvz", {N_sig, V_sig, Z_sig}, 3'b010);
        issue(OP_SUB, 16'h0005, 16'h0005);
        check("sub_zero_nvz", {N_sig, V_sig, Z_sig}, 3'b001);
        issue(OP_SHL, 16'h0001, 16'hFF0F);
        check("shl_out", out, 16'h8000);
        issue(OP_XOR, 16'hAAAA, 16'hFFFF);
        check("xor_out", out, 16'h5555);
        issue(OP_NOTB, 16'h1234, 16'h00FF);
        issue(OP_AND, 16'hF0F0, 16'h3C3C);
        issue(OP_OR, 16'hF000, 16'h000F);

        // Multiply latency and results.
        mul_latency(16'h0100, 16'h0100);
        check("mul1_out", out, 16'h0000);
        check("mul1_nvz", {N_sig, V_sig, Z_sig}, 3'b011);
        mul_latency(16'h00FF, 16'h0003);
        check("mul2_out", out, 16'h02FD);
        check("mul2_v", V_sig, 0);

        // Back-pressure: slot full blocks the MUL until the ADD drains.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        issue(OP_ADD, 16'h0003, 16'h0004);
        check("bp_in_ready", in_ready, 0);
        ALUop    = OP_MUL;
        Ain      = 16'h0011;
        Bin      = 16'h0022;
        in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("bp_stall_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_drain_ready", in_ready, 1);
        @(posedge clk);
        sb_q.push_back(model(OP_MUL, 16'h0011, 16'h0022));
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("bp_mul_valid", out_valid, 1);
        check("bp_mul_idle", {busy, in_ready}, 2'b00);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_popped", out_valid, 0);

        // Reset in the middle of a multiply.
        issue(OP_MUL, 16'h1234, 16'h0042);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midmul_rst_outputs", {out, N_sig, V_sig, Z_sig, out_valid, busy}, 0);
        sb_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        issue(OP_ADD, 16'h0002, 16'h0003);
        check("post_rst_valid", out_valid, 1);
        check("post_rst_out", out, 16'h0005);

        // Random ops with random consumer back-pressure.
        bp_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            issue(alu_op_t'(3'($urandom_range(0, 7))), W'($urandom), W'($urandom));
        end
        issue(OP_ADD, 16'h8000, 16'h8000);
        issue(OP_SUB, 16'h7FFF, 16'hFFFF);
        issue(OP_MUL, 16'hFFFF, 16'hFFFF);
        bp_en = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        check("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
